// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_pkg
// Description : Shared types, constants and operand-decode helpers for the
//               iterative RV32M multiply/divide sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    // Encodings match the RV32M funct3 field so op_i can be cast directly.
    typedef enum logic [2:0] {
        MDU_MUL    = 3'b000,
        MDU_MULH   = 3'b001,
        MDU_MULHSU = 3'b010,
        MDU_MULHU  = 3'b011,
        MDU_DIV    = 3'b100,
        MDU_DIVU   = 3'b101,
        MDU_REM    = 3'b110,
        MDU_REMU   = 3'b111
    } mdu_op_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_CALC = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } mdu_state_t;

    localparam int unsigned MDU_ITERATIONS = 32;
    localparam logic [31:0] DIV_OVF_QUOT   = 32'h8000_0000;
    localparam logic [31:0] DIV_ZERO_QUOT  = 32'hFFFF_FFFF;

    // funct3[2] separates the divide family from the multiply family.
    function automatic logic op_is_div(input mdu_op_t op);
        return op[2];
    endfunction

    // Operand A (rs1) is signed for MUL, MULH, MULHSU, DIV and REM.
    function automatic logic op_a_signed(input mdu_op_t op);
        return (op == MDU_MUL) || (op == MDU_MULH) || (op == MDU_MULHSU) ||
               (op == MDU_DIV) || (op == MDU_REM);
    endfunction

    // Operand B (rs2) is signed for MUL, MULH, DIV and REM.
    function automatic logic op_b_signed(input mdu_op_t op);
        return (op == MDU_MUL) || (op == MDU_MULH) ||
               (op == MDU_DIV) || (op == MDU_REM);
    endfunction

endpackage : mdu_pkg
`default_nettype wire

// File: rtl/mdu_step.sv
`default_nettype none
// ============================================================================
// Module      : mdu_step
// Description : One combinational iteration of the shared multiply/divide
//               datapath. Both modes consume the shift register MSB-first.
//   Multiply : acc <- (acc << 1) + (shq[MSB] ? |B| : 0); shq <- shq << 1
//              After XLEN steps acc holds the full 2*XLEN-bit product.
//   Divide   : restoring. {rem,shq} shifted left by one, |B| trial-subtracted
//              from the partial remainder; on no borrow the difference is kept
//              and a 1 enters the quotient (shq LSB), otherwise a 0.
//              The remainder lives in acc[XLEN:0].
// Ports       : i_acc, i_shq, i_abs_b, i_is_div -> o_acc, o_shq
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_step #(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0] i_acc,
    input  logic [XLEN-1:0]   i_shq,
    input  logic [XLEN-1:0]   i_abs_b,
    input  logic              i_is_div,
    output logic [2*XLEN-1:0] o_acc,
    output logic [XLEN-1:0]   o_shq
);

    logic [XLEN:0]     w_rem_sh;   // partial remainder after the left shift
    logic [XLEN+1:0]   w_diff;     // trial difference; MSB is the borrow
    logic [2*XLEN-1:0] w_addend;

    always_comb begin
        w_rem_sh = {i_acc[XLEN-1:0], i_shq[XLEN-1]};
        w_diff   = {1'b0, w_rem_sh} - {2'b00, i_abs_b};
        w_addend = i_shq[XLEN-1] ? {{XLEN{1'b0}}, i_abs_b} : '0;

        o_acc = {i_acc[2*XLEN-2:0], 1'b0} + w_addend;
        o_shq = {i_shq[XLEN-2:0], 1'b0};

        if (i_is_div) begin
            if (!w_diff[XLEN+1]) begin
                o_acc = {{(XLEN-1){1'b0}}, w_diff[XLEN:0]};
                o_shq = {i_shq[XLEN-2:0], 1'b1};
            end else begin
                o_acc = {{(XLEN-1){1'b0}}, w_rem_sh};
            end
        end
    end

endmodule : mdu_step
`default_nettype wire

// File: rtl/mdu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mdu_sequencer
// Description : Iterative RV32M multiply/divide unit for the EX stage.
//               Accepts one operation per start pulse, runs 32 shift/add or
//               shift/subtract iterations and returns the result with a
//               one-cycle ready pulse. busy_o stalls the pipeline while the
//               operation is in flight; flush_i aborts it cleanly.
// Ports       : clk, rst_n (async, active-low)
//               valid_i, flush_i, op_i[2:0] (funct3), rs1_i, rs2_i
//               busy_o, ready_o, result_o (registered, held until next result)
// Note        : datapath is written for XLEN = 32 only.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    input  logic            flush_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            busy_o,
    output logic            ready_o,
    output logic [XLEN-1:0] result_o
);

    mdu_state_t        r_state;
    mdu_state_t        w_next_state;

    mdu_op_t           r_op;
    logic [XLEN-1:0]   r_a;        // rs1 on accept, |A| / quotient afterwards
    logic [XLEN-1:0]   r_b;        // rs2 on accept, |B| afterwards
    logic [2*XLEN-1:0] r_acc;      // product, or partial remainder in low bits
    logic [5:0]        r_cnt;
    logic              r_neg_res;  // negate product / quotient
    logic              r_neg_rem;  // remainder takes the dividend's sign
    logic [XLEN-1:0]   r_result;

    logic              w_accept;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_abs_a;
    logic [XLEN-1:0]   w_abs_b;
    logic              w_div_zero;
    logic              w_div_ovf;
    logic              w_special;
    logic [XLEN-1:0]   w_special_res;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_fix_res;
    logic [2*XLEN-1:0] w_step_acc;
    logic [XLEN-1:0]   w_step_shq;

    assign w_accept = valid_i && !flush_i &&
                      ((r_state == ST_IDLE) || (r_state == ST_DONE));

    // ------------------------------------------------------------------
    // PREP-stage operand conditioning and special-case detection.
    // r_a / r_b still hold the raw rs1 / rs2 while in PREP.
    // ------------------------------------------------------------------
    always_comb begin
        w_a_neg    = op_a_signed(r_op) && r_a[XLEN-1];
        w_b_neg    = op_b_signed(r_op) && r_b[XLEN-1];
        w_abs_a    = w_a_neg ? -r_a : r_a;
        w_abs_b    = w_b_neg ? -r_b : r_b;
        w_div_zero = op_is_div(r_op) && (r_b == '0);
        w_div_ovf  = ((r_op == MDU_DIV) || (r_op == MDU_REM)) &&
                     (r_a == DIV_OVF_QUOT) && (r_b == '1);
        w_special  = w_div_zero || w_div_ovf;

        if (w_div_zero) begin
            w_special_res = ((r_op == MDU_DIV) || (r_op == MDU_DIVU)) ? DIV_ZERO_QUOT : r_a;
        end else begin
            w_special_res = (r_op == MDU_DIV) ? DIV_OVF_QUOT : '0;
        end
    end

    // ------------------------------------------------------------------
    // FIX-stage sign correction and result selection.
    // ------------------------------------------------------------------
    always_comb begin
        w_prod = r_neg_res ? -r_acc : r_acc;
        w_quo  = r_neg_res ? -r_a : r_a;
        w_rem  = r_neg_rem ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];

        case (r_op)
            MDU_MUL:                        w_fix_res = w_prod[XLEN-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU: w_fix_res = w_prod[2*XLEN-1:XLEN];
            MDU_DIV, MDU_DIVU:              w_fix_res = w_quo;
            MDU_REM, MDU_REMU:              w_fix_res = w_rem;
            default:                        w_fix_res = '0;
        endcase
    end

    mdu_step #(
        .XLEN (XLEN)
    ) u_step (
        .i_acc    (r_acc),
        .i_shq    (r_a),
        .i_abs_b  (r_b),
        .i_is_div (op_is_div(r_op)),
        .o_acc    (w_step_acc),
        .o_shq    (w_step_shq)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and status outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        busy_o       = 1'b0;
        ready_o      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (valid_i) w_next_state = ST_PREP;
            end
            ST_PREP: begin
                busy_o       = 1'b1;
                w_next_state = w_special ? ST_DONE : ST_CALC;
            end
            ST_CALC: begin
                busy_o = 1'b1;
                // Counter reaches zero on this edge: last iteration.
                if (r_cnt == 6'd1) w_next_state = ST_FIX;
            end
            ST_FIX: begin
                busy_o       = 1'b1;
                w_next_state = ST_DONE;
            end
            ST_DONE: begin
                ready_o      = 1'b1;
                w_next_state = valid_i ? ST_PREP : ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase

        // Flush beats everything, including a simultaneous start.
        if (flush_i) w_next_state = ST_IDLE;
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op      <= MDU_MUL;
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_result  <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        r_op <= mdu_op_t'(op_i);
                        r_a  <= rs1_i;
                        r_b  <= rs2_i;
                    end
                end
                ST_PREP: begin
                    r_a       <= w_abs_a;
                    r_b       <= w_abs_b;
                    r_acc     <= '0;
                    r_cnt     <= 6'(MDU_ITERATIONS);
                    r_neg_res <= w_a_neg ^ w_b_neg;
                    r_neg_rem <= w_a_neg;
                    if (w_special && !flush_i) r_result <= w_special_res;
                end
                ST_CALC: begin
                    r_acc <= w_step_acc;
                    r_a   <= w_step_shq;
                    r_cnt <= r_cnt - 6'd1;
                end
                ST_FIX: begin
                    if (!flush_i) r_result <= w_fix_res;
                end
                default: begin
                end
            endcase
        end
    end

    assign result_o = r_result;

endmodule : mdu_sequencer
`default_nettype wire

// File: tb/tb_mdu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_sequencer
// Description : Directed self-checking bench for mdu_sequencer. Inputs are
//               driven 1 time unit after each rising edge, outputs sampled
//               at the same point. "Cycle n" counts from the accept edge:
//               cycle 1 is PREP, cycle 35 is DONE for a full operation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_sequencer;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic        flush;
    logic [2:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        busy;
    logic        ready;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mdu_sequencer #(
        .XLEN (32)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_i  (valid),
        .flush_i  (flush),
        .op_i     (op),
        .rs1_i    (rs1),
        .rs2_i    (rs2),
        .busy_o   (busy),
        .ready_o  (ready),
        .result_o (result)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request now; it is accepted on the next edge (E0).
    task automatic start(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        valid = 1'b1;
        op    = o;
        rs1   = a;
        rs2   = b;
        tick();
        valid = 1'b0;
        rs1   = '0;
        rs2   = '0;
    endtask

    // Called in cycle 1; returns the cycle in which ready was seen and the
    // number of busy cycles before it. Bounded so a dead DUT cannot hang.
    task automatic wait_ready(output int n, output int busy_n);
        n      = 1;
        busy_n = 0;
        while (ready !== 1'b1 && n < 100) begin
            if (busy === 1'b1) busy_n++;
            tick();
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int n;
        int bn;
        start(o, a, b);
        wait_ready(n, bn);
        chk({tag, " result"}, result, exp);
        chk({tag, " latency"}, 32'(n), 32'(lat));
    endtask

    initial begin
        int n;
        int bn;
        logic seen;

        rst_n = 1'b0;
        valid = 1'b0;
        flush = 1'b0;
        op    = '0;
        rs1   = '0;
        rs2   = '0;
        repeat (2) tick();
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset ready", {31'd0, ready}, 32'd0);
        chk("reset result", result, 32'd0);
        rst_n = 1'b1;
        tick();

        // MUL 7 * -3 with full timing checks
        start(OP_MUL, 32'd7, 32'hFFFF_FFFD);
        wait_ready(n, bn);
        chk("mul result", result, 32'hFFFF_FFEB);
        chk("mul latency", 32'(n), 32'd35);
        chk("mul busy cycles", 32'(bn), 32'd34);
        chk("mul busy in done", {31'd0, busy}, 32'd0);
        tick();
        chk("mul ready pulse", {31'd0, ready}, 32'd0);
        chk("mul result held", result, 32'hFFFF_FFEB);

        run_op("mulh", OP_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 35);
        tick();
        run_op("mulhu", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 35);
        tick();
        run_op("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 35);
        tick();
        run_op("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 35);
        tick();
        run_op("rem", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 35);
        tick();
        run_op("divu", OP_DIVU, 32'd100, 32'd7, 32'd14, 35);
        tick();
        run_op("remu", OP_REMU, 32'd100, 32'd7, 32'd2, 35);
        // Still in the DONE cycle of REMU: issue back-to-back
        run_op("mul b2b", OP_MUL, 32'd3, 32'd4, 32'd12, 35);
        tick();

        // Flush in CALC, cycle 10
        start(OP_DIV, 32'd1000, 32'd3);
        repeat (9) tick();
        chk("pre-flush busy", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush busy", {31'd0, busy}, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            seen = seen | ready;
            tick();
        end
        chk("flush no ready", {31'd0, seen}, 32'd0);
        chk("flush result held", result, 32'd12);

        // Flush coincident with valid in IDLE
        valid = 1'b1;
        flush = 1'b1;
        op    = OP_MUL;
        rs1   = 32'd2;
        rs2   = 32'd2;
        tick();
        valid = 1'b0;
        flush = 1'b0;
        chk("flush+valid busy", {31'd0, busy}, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            seen = seen | ready | busy;
            tick();
        end
        chk("flush+valid idle", {31'd0, seen}, 32'd0);
        chk("flush+valid result", result, 32'd12);

        // Special cases finish in cycle 2
        run_op("divu by 0", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 2);
        tick();
        run_op("rem by 0", OP_REM, 32'd5, 32'd0, 32'd5, 2);
        tick();
        run_op("rem ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2);
        tick();
        run_op("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
        tick();

        // Asynchronous reset in cycle 20 of a DIV
        start(OP_DIV, 32'd1000, 32'd3);
        repeat (19) tick();
        chk("pre-reset busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async reset busy", {31'd0, busy}, 32'd0);
        chk("async reset ready", {31'd0, ready}, 32'd0);
        chk("async reset result", result, 32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        seen = 1'b0;
        repeat (40) begin
            seen = seen | ready | busy;
            tick();
        end
        chk("post-reset idle", {31'd0, seen}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mdu_sequencer
`default_nettype wire
